// File: rtl/sid_pkg.sv
// Shared types for the SID host-side bus: request bundle, target select and
// host FSM states.
package sid_pkg;

    typedef enum logic [1:0] {
        SEL_D400 = 2'd0,
        SEL_D420 = 2'd1,
        SEL_D500 = 2'd2,
        SEL_DE00 = 2'd3
    } host_sel_t;

    typedef struct packed {
        logic      rw;
        host_sel_t sel;
        logic [4:0] addr;
        logic [7:0] data;
    } host_req_t;

    typedef enum logic [1:0] {
        ST_RES_HOLD = 2'd0,
        ST_IDLE     = 2'd1,
        ST_XFER     = 2'd2
    } host_state_t;

    localparam int HOST_FIFO_DEPTH = 4;

endpackage

// File: rtl/sid_bus_host_fifo.sv
// Four-entry request FIFO for sid_bus_host; push and pop in the same clk
// leave the occupancy unchanged.
module sid_bus_host_fifo
    import sid_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  host_req_t din_i,
    output host_req_t dout_o,
    output logic      empty_o,
    output logic      full_o
);

    host_req_t  mem_q [HOST_FIFO_DEPTH];
    logic [1:0] wr_q;
    logic [1:0] rd_q;
    logic [2:0] cnt_q;
    logic       do_push;
    logic       do_pop;

    assign empty_o = (cnt_q == 3'd0);
    assign full_o  = (cnt_q == 3'(HOST_FIFO_DEPTH));
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HOST_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 2'd1;
            end
            if (do_pop) rd_q <= rd_q + 2'd1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 3'd1;
            else if (do_pop && !do_push) cnt_q <= cnt_q - 3'd1;
        end
    end

endmodule

// File: rtl/sid_bus_host.sv
// SID host-bus initiator: phi2 generation, power-on reset, register cycles.
// Define SID_BUS_HOST_FIFO_EN for a 4-deep request FIFO (else one register).
module sid_bus_host
    import sid_pkg::*;
#(
    parameter int PHI2_HALF  = 12,
    parameter int RES_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [1:0] req_sel,
    input  logic [4:0] req_addr,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       phi2,
    output logic       res_n,
    output logic       r_w_n,
    output logic       cs_n,
    output logic       cs_io1_n,
    output logic       a5,
    output logic       a8,
    output logic [4:0] addr,
    output logic [7:0] data_o,
    output logic       data_oe,
    input  logic [7:0] data_i
);

    localparam int PH_W = $clog2(2 * PHI2_HALF);
    localparam int RC_W = $clog2(RES_CYCLES) + 1;

    host_state_t      state_q, state_d;
    logic [PH_W-1:0]  ph_q;
    logic [RC_W-1:0]  res_cnt_q, res_cnt_d;
    host_req_t        cur_q, cur_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             last;
    logic             xfer;
    logic             q_push, q_pop, q_empty, q_full;
    host_req_t        q_head, req_in;

    assign last   = (ph_q == PH_W'(2 * PHI2_HALF - 1));
    assign phi2   = (ph_q >= PH_W'(PHI2_HALF));
    assign req_in = '{rw: req_rw, sel: host_sel_t'(req_sel),
                      addr: req_addr, data: req_data};
    assign q_push = req_valid && req_ready;
    // Registered occupancy: a request taken on Last waits for the next Last.
    assign q_pop  = last && (state_q != ST_RES_HOLD) && !q_empty;

`ifdef SID_BUS_HOST_FIFO_EN
    sid_bus_host_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .din_i   (req_in),
        .dout_o  (q_head),
        .empty_o (q_empty),
        .full_o  (q_full)
    );
`else
    host_req_t pend_q;
    logic      pend_vld_q;

    assign q_head  = pend_q;
    assign q_empty = !pend_vld_q;
    assign q_full  = pend_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            if (q_push) pend_q <= req_in;
            if (q_push)     pend_vld_q <= 1'b1;
            else if (q_pop) pend_vld_q <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RES_HOLD;
            ph_q        <= '0;
            res_cnt_q   <= '0;
            cur_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= last ? '0 : ph_q + PH_W'(1);
            res_cnt_q   <= res_cnt_d;
            cur_q       <= cur_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        res_cnt_d   = res_cnt_q;
        cur_d       = q_pop ? q_head : cur_q;
        rsp_valid_d = last && (state_q == ST_XFER) && cur_q.rw;
        rsp_data_d  = rsp_valid_d ? data_i : rsp_data_q;
        unique case (state_q)
            ST_RES_HOLD: begin
                if (last) begin
                    if (res_cnt_q == RC_W'(RES_CYCLES - 1)) state_d = ST_IDLE;
                    else res_cnt_d = res_cnt_q + RC_W'(1);
                end
            end
            ST_IDLE, ST_XFER: begin
                if (last) state_d = q_empty ? ST_IDLE : ST_XFER;
            end
            default: state_d = ST_RES_HOLD;
        endcase
    end

    assign xfer      = (state_q == ST_XFER);
    assign res_n     = (state_q != ST_RES_HOLD);
    assign req_ready = res_n && !q_full;
    assign r_w_n     = xfer ? cur_q.rw : 1'b1;
    assign cs_n      = !(xfer && (cur_q.sel != SEL_DE00));
    assign cs_io1_n  = !(xfer && (cur_q.sel == SEL_DE00));
    assign a5        = (cur_q.sel == SEL_D420);
    assign a8        = (cur_q.sel == SEL_D500);
    assign addr      = cur_q.addr;
    assign data_o    = cur_q.data;
    assign data_oe   = xfer && !cur_q.rw && phi2;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sid_bus_host.sv
// Directed bench for sid_bus_host (PHI2_HALF=12, RES_CYCLES=8).
module tb_sid_bus_host;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_rw;
    logic [1:0] req_sel;
    logic [4:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       phi2, res_n, r_w_n, cs_n, cs_io1_n, a5, a8;
    logic [4:0] addr;
    logic [7:0] data_o;
    logic       data_oe;
    logic [7:0] data_i;

    int n;
    int tests = 0;
    int fails = 0;
    int bad;

    always #5 clk = ~clk;

    sid_bus_host #(.PHI2_HALF(12), .RES_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_sel(req_sel), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .phi2(phi2), .res_n(res_n), .r_w_n(r_w_n),
        .cs_n(cs_n), .cs_io1_n(cs_io1_n), .a5(a5), .a8(a8),
        .addr(addr), .data_o(data_o), .data_oe(data_oe), .data_i(data_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic to_ph(input int p);
        while ((n % 24) != p) tick();
    endtask

    task automatic do_req(input logic rw, input logic [1:0] sel,
                          input logic [4:0] a, input logic [7:0] d);
        req_rw = rw; req_sel = sel; req_addr = a; req_data = d;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_sel = 2'd0;
        req_addr = 5'd0; req_data = 8'd0; data_i = 8'd0; n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phi2", phi2, 0);
        chk("rst_res_n", res_n, 0);
        chk("rst_r_w_n", r_w_n, 1);
        chk("rst_cs_n", cs_n, 1);
        chk("rst_cs_io1_n", cs_io1_n, 1);
        chk("rst_a5", a5, 0);
        chk("rst_a8", a8, 0);
        chk("rst_addr", addr, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_req_ready", req_ready, 0);

        rst = 1'b0; n = 0;
        repeat (11) tick();
        chk("phi2_low_ph11", phi2, 0);
        tick();
        chk("phi2_high_ph12", phi2, 1);
        repeat (12) tick();
        chk("phi2_low_ph24", phi2, 0);
        while (n < 191) tick();
        chk("res_n_low_191", res_n, 0);
        chk("ready_low_191", req_ready, 0);
        tick();
        chk("res_n_high_192", res_n, 1);
        chk("ready_high_192", req_ready, 1);

        do_req(1'b0, 2'd0, 5'h18, 8'h0F);
`ifndef SID_BUS_HOST_FIFO_EN
        chk("wr_ready_full", req_ready, 0);
`endif
        chk("wr_not_yet", cs_n, 1);
        to_ph(0);
        chk("wr_cs_n", cs_n, 0);
        chk("wr_a5", a5, 0);
        chk("wr_a8", a8, 0);
        chk("wr_r_w_n", r_w_n, 0);
        chk("wr_addr", addr, 5'h18);
        chk("wr_data_o", data_o, 8'h0F);
        chk("wr_oe_phi2_low", data_oe, 0);
        to_ph(12);
        chk("wr_oe_phi2_high", data_oe, 1);
        to_ph(23);
        chk("wr_cs_last", cs_n, 0);
        chk("wr_oe_last", data_oe, 1);
        tick();
        chk("wr_end_cs_n", cs_n, 1);
        chk("wr_end_oe", data_oe, 0);
        chk("wr_end_r_w_n", r_w_n, 1);
        chk("wr_end_addr_hold", addr, 5'h18);

        do_req(1'b1, 2'd1, 5'h1B, 8'h00);
        to_ph(0);
        chk("rd1_cs_n", cs_n, 0);
        chk("rd1_a5", a5, 1);
        chk("rd1_a8", a8, 0);
        chk("rd1_r_w_n", r_w_n, 1);
        chk("rd1_addr", addr, 5'h1B);
        chk("rd1_oe_low", data_oe, 0);
        to_ph(12);
        chk("rd1_oe_high", data_oe, 0);
        to_ph(23);
        data_i = 8'hA5;
        chk("rd1_no_rsp_yet", rsp_valid, 0);
        tick();
        data_i = 8'h00;
        chk("rd1_rsp_valid", rsp_valid, 1);
        chk("rd1_rsp_data", rsp_data, 8'hA5);
        chk("rd1_cs_released", cs_n, 1);
        tick();
        chk("rd1_rsp_pulse", rsp_valid, 0);
        chk("rd1_rsp_hold", rsp_data, 8'hA5);

        to_ph(23);
        req_rw = 1'b1; req_sel = 2'd3; req_addr = 5'h02; req_data = 8'h00;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("last_acc_not_popped", cs_io1_n, 1);
        tick();
        to_ph(0);
        chk("rd3_cs_io1_n", cs_io1_n, 0);
        chk("rd3_cs_n", cs_n, 1);
        chk("rd3_r_w_n", r_w_n, 1);
        chk("rd3_addr", addr, 5'h02);
        to_ph(23);
        data_i = 8'h3C;
        tick();
        data_i = 8'h00;
        chk("rd3_rsp_valid", rsp_valid, 1);
        chk("rd3_rsp_data", rsp_data, 8'h3C);

        do_req(1'b0, 2'd2, 5'h05, 8'h77);
        to_ph(0);
        chk("wr2_cs_n", cs_n, 0);
        chk("wr2_a8", a8, 1);
        chk("wr2_a5", a5, 0);
        chk("wr2_addr", addr, 5'h05);
        do_req(1'b0, 2'd0, 5'h01, 8'h11);
        to_ph(12);
        chk("wr2_data_o", data_o, 8'h77);
        chk("wr2_oe", data_oe, 1);
        to_ph(0);
        chk("b2b_cs_n", cs_n, 0);
        chk("b2b_addr", addr, 5'h01);
        chk("b2b_data_o", data_o, 8'h11);
        chk("b2b_a8", a8, 0);
        chk("b2b_r_w_n", r_w_n, 0);
        tick();
        to_ph(0);
        chk("b2b_idle", cs_n, 1);

`ifdef SID_BUS_HOST_FIFO_EN
        req_rw = 1'b0; req_sel = 2'd0; req_data = 8'h5A;
        req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_addr = 5'(k);
            tick();
        end
        req_addr = 5'd4;
        chk("fifo_full_ready", req_ready, 0);
        to_ph(23);
        chk("fifo_stall_last", req_ready, 0);
        tick();
        chk("fifo_ready_after_pop", req_ready, 1);
        chk("fifo_bus0_addr", addr, 0);
        chk("fifo_bus0_cs", cs_n, 0);
        tick();
        req_valid = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            to_ph(0);
            chk("fifo_bus_addr", addr, k);
            chk("fifo_bus_cs", cs_n, 0);
        end
        tick();
        to_ph(0);
        chk("fifo_drained", cs_n, 1);
`endif

        do_req(1'b0, 2'd0, 5'h0A, 8'h55);
        to_ph(0);
        do_req(1'b1, 2'd3, 5'h0C, 8'h00);
        to_ph(15);
        chk("mid_oe_before_rst", data_oe, 1);
        chk("mid_cs_before_rst", cs_n, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", cs_n, 1);
        chk("mid_rst_oe", data_oe, 0);
        chk("mid_rst_res_n", res_n, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_phi2", phi2, 0);
        chk("mid_rst_addr", addr, 0);
        #1;
        rst = 1'b0;
        n = 0;
        bad = 0;
        for (int k = 0; k < 192 + 48; k++) begin
            tick();
            if (!cs_n || !cs_io1_n || rsp_valid || data_oe) bad++;
        end
        chk("no_queued_after_rst", bad, 0);
        chk("res_n_after_rst", res_n, 1);
        chk("ready_after_rst", req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
